// File: rtl/alu_defs_pkg.sv
// Shared decode constants, decoded-entry struct and skid-buffer state type
// for the ID->EX ALU issue stage.
package alu_defs;

  localparam logic [3:0] ALUC_AND = 4'd0;
  localparam logic [3:0] ALUC_OR  = 4'd1;
  localparam logic [3:0] ALUC_ADD = 4'd2;
  localparam logic [3:0] ALUC_SUB = 4'd6;
  localparam logic [3:0] ALUC_SLT = 4'd7;
  localparam logic [3:0] ALUC_NOR = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;

  typedef struct packed {
    logic [3:0]  aluc;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  wn;
    logic        wreg;
    logic        illegal;
  } entry_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/alu_dec.sv
// Combinational MIPS op/funct decode into ALU control, operand B select and
// write-enable; anything not recognised is flagged illegal.
module alu_dec
  import alu_defs::*;
(
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic [31:0] qb,
  input  logic [15:0] imm,
  output logic [3:0]  aluc,
  output logic [31:0] b,
  output logic        wreg,
  output logic        illegal
);

  logic [31:0] simm, zimm;

  assign simm = {{16{imm[15]}}, imm};
  assign zimm = {16'h0000, imm};

  always_comb begin
    aluc    = ALUC_AND;
    b       = qb;
    wreg    = 1'b1;
    illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_AND:           aluc = ALUC_AND;
          FN_OR:            aluc = ALUC_OR;
          FN_ADD, FN_ADDU:  aluc = ALUC_ADD;
          FN_SUB, FN_SUBU:  aluc = ALUC_SUB;
          FN_SLT:           aluc = ALUC_SLT;
          FN_NOR:           aluc = ALUC_NOR;
          default: begin
            wreg    = 1'b0;
            illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin aluc = ALUC_ADD; b = simm; end
      OP_SLTI:           begin aluc = ALUC_SLT; b = simm; end
      OP_ANDI:           begin aluc = ALUC_AND; b = zimm; end
      OP_ORI:            begin aluc = ALUC_OR;  b = zimm; end
      default: begin
        wreg    = 1'b0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: decodes into an ALU entry and hands it to EX through a
// 2-entry skid buffer; counts accepted illegal instructions (saturating).
module alu_issue_stage
  import alu_defs::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             d_valid,
  output logic             d_ready,
  input  logic [5:0]       d_op,
  input  logic [5:0]       d_funct,
  input  logic [31:0]      d_qa,
  input  logic [31:0]      d_qb,
  input  logic [15:0]      d_imm,
  input  logic [4:0]       d_wn,
  input  logic             flush,
  input  logic             e_ready,
  output logic             e_valid,
  output logic [3:0]       ealuc,
  output logic [31:0]      ea,
  output logic [31:0]      eb,
  output logic [4:0]       ewn,
  output logic             ewreg,
  output logic             e_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  buf_state_t state, nstate;
  entry_t     head, skid, dec_ent;
  logic [3:0]  dec_aluc;
  logic [31:0] dec_b;
  logic        dec_wreg, dec_illegal;
  logic        in_x, out_x;

  alu_dec u_dec (
    .op      (d_op),
    .funct   (d_funct),
    .qb      (d_qb),
    .imm     (d_imm),
    .aluc    (dec_aluc),
    .b       (dec_b),
    .wreg    (dec_wreg),
    .illegal (dec_illegal)
  );

  assign dec_ent = '{aluc: dec_aluc, a: d_qa, b: dec_b, wn: d_wn,
                     wreg: dec_wreg, illegal: dec_illegal};

  assign e_valid = (state != BUF_EMPTY);
  assign in_x    = d_valid & d_ready;
  assign out_x   = e_valid & e_ready;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= BUF_EMPTY;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    if (flush) begin
      nstate = BUF_EMPTY;
    end else begin
      case (state)
        BUF_EMPTY: if (in_x) nstate = BUF_ONE;
        BUF_ONE: begin
          if (in_x && !out_x)      nstate = BUF_FULL;
          else if (!in_x && out_x) nstate = BUF_EMPTY;
        end
        BUF_FULL:  if (out_x) nstate = BUF_ONE;
        default:   nstate = BUF_EMPTY;
      endcase
    end
  end

  // Head always feeds EX; the skid only catches the entry that arrives while
  // the head is stalled, so d_ready can stay a plain register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      head    <= '0;
      skid    <= '0;
      d_ready <= 1'b1;
    end else begin
      d_ready <= (nstate != BUF_FULL);
      if (!flush) begin
        if (in_x && (state == BUF_EMPTY || (state == BUF_ONE && out_x)))
          head <= dec_ent;
        else if (state == BUF_FULL && out_x)
          head <= skid;
        if (in_x && state == BUF_ONE && !out_x)
          skid <= dec_ent;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)
      illegal_cnt <= '0;
    else if (in_x && dec_illegal && !flush && illegal_cnt != {CNT_W{1'b1}})
      illegal_cnt <= illegal_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign ealuc     = head.aluc;
  assign ea        = head.a;
  assign eb        = head.b;
  assign ewn       = head.wn;
  assign ewreg     = head.wreg;
  assign e_illegal = head.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomised bench for alu_issue_stage: a queue-based reference model is
// compared against the outputs every cycle, plus directed literal checks.
module tb_alu_issue_stage;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk, clrn;
  logic             d_valid, d_ready;
  logic [5:0]       d_op, d_funct;
  logic [31:0]      d_qa, d_qb;
  logic [15:0]      d_imm;
  logic [4:0]       d_wn;
  logic             flush, e_ready, e_valid;
  logic [3:0]       ealuc;
  logic [31:0]      ea, eb;
  logic [4:0]       ewn;
  logic             ewreg, e_illegal;
  logic [CNT_W-1:0] illegal_cnt;

  alu_issue_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .clrn(clrn), .d_valid(d_valid), .d_ready(d_ready),
    .d_op(d_op), .d_funct(d_funct), .d_qa(d_qa), .d_qb(d_qb),
    .d_imm(d_imm), .d_wn(d_wn), .flush(flush), .e_ready(e_ready),
    .e_valid(e_valid), .ealuc(ealuc), .ea(ea), .eb(eb), .ewn(ewn),
    .ewreg(ewreg), .e_illegal(e_illegal), .illegal_cnt(illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  aluc;
    logic [31:0] a, b;
    logic [4:0]  wn;
    logic        wreg, ill;
  } exp_t;

  exp_t q[$];
  int   mcnt;
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Architectural meaning of each instruction, straight from the opcode tables.
  function automatic exp_t ref_dec(input logic [5:0] op, input logic [5:0] fn,
                                   input logic [31:0] qa, input logic [31:0] qb,
                                   input logic [15:0] imm, input logic [4:0] wn);
    exp_t r;
    logic [31:0] sx, zx;
    sx = 32'($signed(imm));
    zx = 32'(imm);
    r.a = qa; r.wn = wn; r.b = qb; r.wreg = 1'b1; r.ill = 1'b0; r.aluc = 4'd0;
    if (op == 6'h00) begin
      case (fn)
        6'h24: r.aluc = 4'd0;
        6'h25: r.aluc = 4'd1;
        6'h20, 6'h21: r.aluc = 4'd2;
        6'h22, 6'h23: r.aluc = 4'd6;
        6'h2a: r.aluc = 4'd7;
        6'h27: r.aluc = 4'd12;
        default: begin r.wreg = 1'b0; r.ill = 1'b1; end
      endcase
    end else begin
      case (op)
        6'h08, 6'h09: begin r.aluc = 4'd2; r.b = sx; end
        6'h0a: begin r.aluc = 4'd7; r.b = sx; end
        6'h0c: begin r.aluc = 4'd0; r.b = zx; end
        6'h0d: begin r.aluc = 4'd1; r.b = zx; end
        default: begin r.wreg = 1'b0; r.ill = 1'b1; end
      endcase
    end
    return r;
  endfunction

  // Reference: a FIFO of at most two entries plus a saturating counter.
  always @(posedge clk or negedge clrn) begin
    exp_t e;
    bit   in_t, out_t;
    if (!clrn) begin
      q.delete();
      mcnt = 0;
    end else begin
      in_t  = d_valid && (q.size() < 2);
      out_t = (q.size() > 0) && e_ready;
      if (flush) q.delete();
      else begin
        e = ref_dec(d_op, d_funct, d_qa, d_qb, d_imm, d_wn);
        if (out_t) void'(q.pop_front());
        if (in_t) begin
          q.push_back(e);
          if (e.ill && mcnt < CNT_MAX) mcnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (clrn === 1'b1) begin
      check("m_d_ready", d_ready, q.size() < 2);
      check("m_e_valid", e_valid, q.size() > 0);
      check("m_cnt", illegal_cnt, mcnt);
      if (q.size() > 0) begin
        check("m_ealuc", ealuc, q[0].aluc);
        check("m_ea", ea, q[0].a);
        check("m_eb", eb, q[0].b);
        check("m_ewn", ewn, q[0].wn);
        check("m_ewreg", ewreg, q[0].wreg);
        check("m_e_illegal", e_illegal, q[0].ill);
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic put(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] qa,
                     input logic [31:0] qb, input logic [15:0] imm, input logic [4:0] wn);
    d_valid = 1'b1; d_op = op; d_funct = fn; d_qa = qa; d_qb = qb; d_imm = imm; d_wn = wn;
  endtask

  initial begin
    logic [5:0] oplist [8];
    logic [5:0] fnlist [8];
    oplist = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0a, 6'h0c, 6'h0d};
    fnlist = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2a};
    clrn = 1'b0; d_valid = 1'b0; d_op = '0; d_funct = '0; d_qa = '0; d_qb = '0;
    d_imm = '0; d_wn = '0; flush = 1'b0; e_ready = 1'b0;
    repeat (2) cyc();
    check("rst_e_valid", e_valid, 0);
    check("rst_d_ready", d_ready, 1);
    check("rst_cnt", illegal_cnt, 0);
    check("rst_ealuc", ealuc, 0);
    check("rst_ea", ea, 0);
    clrn = 1'b1;
    cyc();

    // SUB decode, single-cycle latency
    put(6'h00, 6'h22, 32'd10, 32'd3, 16'h0, 5'd5); e_ready = 1'b1;
    cyc(); d_valid = 1'b0;
    check("sub_e_valid", e_valid, 1);
    check("sub_ealuc", ealuc, 6);
    check("sub_ea", ea, 10);
    check("sub_eb", eb, 3);
    check("sub_ewreg", ewreg, 1);

    put(6'h08, 6'h00, 32'd1, 32'd2, 16'hffff, 5'd3);
    cyc();
    check("addi_eb", eb, 32'hffffffff);
    check("addi_ealuc", ealuc, 2);
    put(6'h0d, 6'h00, 32'd1, 32'd2, 16'h8000, 5'd3);
    cyc(); d_valid = 1'b0;
    check("ori_eb", eb, 32'h00008000);
    check("ori_ealuc", ealuc, 1);
    cyc();

    // Backpressure: three offered, two accepted, drain in order
    e_ready = 1'b0;
    put(6'h00, 6'h20, 32'd1, 32'd0, 16'h0, 5'd1); cyc();
    check("bp_rdy1", d_ready, 1);
    put(6'h00, 6'h20, 32'd2, 32'd0, 16'h0, 5'd2); cyc();
    check("bp_rdy2", d_ready, 0);
    check("bp_head1", ea, 1);
    put(6'h00, 6'h20, 32'd3, 32'd0, 16'h0, 5'd3); cyc();
    check("bp_rdy3", d_ready, 0);
    check("bp_hold", ea, 1);
    e_ready = 1'b1; cyc();
    check("bp_out2", ea, 2);
    check("bp_rdy4", d_ready, 1);
    cyc(); d_valid = 1'b0;
    check("bp_out3", ea, 3);
    cyc();
    check("bp_empty", e_valid, 0);

    // Illegal instruction
    put(6'h23, 6'h00, 32'd7, 32'd8, 16'h0, 5'd9); cyc(); d_valid = 1'b0;
    check("ill_flag", e_illegal, 1);
    check("ill_wreg", ewreg, 0);
    check("ill_cnt", illegal_cnt, 1);
    cyc();

    // Flush while FULL with a simultaneous offer
    e_ready = 1'b0;
    put(6'h00, 6'h24, 32'd4, 32'd5, 16'h0, 5'd1); cyc(); cyc();
    check("fl_full", d_ready, 0);
    put(6'h3f, 6'h00, 32'd0, 32'd0, 16'h0, 5'd0); flush = 1'b1; cyc();
    flush = 1'b0; d_valid = 1'b0;
    check("flf_e_valid", e_valid, 0);
    check("flf_d_ready", d_ready, 1);
    check("flf_cnt", illegal_cnt, 1);
    // Flush in ONE with an acceptable illegal offer: dropped and uncounted
    put(6'h00, 6'h25, 32'd4, 32'd5, 16'h0, 5'd1); cyc();
    put(6'h3f, 6'h00, 32'd0, 32'd0, 16'h0, 5'd0); flush = 1'b1; cyc();
    flush = 1'b0; d_valid = 1'b0;
    check("flo_e_valid", e_valid, 0);
    check("flo_cnt", illegal_cnt, 1);

    // Saturate the counter
    e_ready = 1'b1;
    repeat (CNT_MAX - 1) begin put(6'h2b, 6'h00, 32'd0, 32'd0, 16'h0, 5'd0); cyc(); end
    d_valid = 1'b0;
    check("sat_max", illegal_cnt, CNT_MAX);
    put(6'h00, 6'h3f, 32'd0, 32'd0, 16'h0, 5'd0); cyc(); d_valid = 1'b0;
    check("sat_hold", illegal_cnt, CNT_MAX);
    cyc();

    // Random stream
    for (int i = 0; i < 400; i++) begin
      d_valid = ($urandom % 4) != 0;
      e_ready = ($urandom % 3) != 0;
      flush   = ($urandom % 25) == 0;
      d_op    = ($urandom % 8 != 0) ? oplist[$urandom % 8] : 6'($urandom);
      d_funct = ($urandom % 8 != 0) ? fnlist[$urandom % 8] : 6'($urandom);
      d_qa = $urandom; d_qb = $urandom; d_imm = 16'($urandom); d_wn = 5'($urandom);
      cyc();
    end
    flush = 1'b0;

    // Asynchronous reset mid-stream, between clock edges
    e_ready = 1'b0;
    put(6'h00, 6'h20, 32'd11, 32'd12, 16'h0, 5'd1); cyc(); cyc();
    d_valid = 1'b0;
    #2 clrn = 1'b0;
    #1;
    check("arst_e_valid", e_valid, 0);
    check("arst_d_ready", d_ready, 1);
    check("arst_cnt", illegal_cnt, 0);
    cyc(); clrn = 1'b1;
    e_ready = 1'b1;
    put(6'h0c, 6'h00, 32'd1, 32'd2, 16'h8001, 5'd4); cyc(); d_valid = 1'b0;
    check("post_eb", eb, 32'h00008001);
    cyc(); cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID→EX issue stage that feeds the execute-stage ALU.
- Decodes MIPS opcode/funct into the 4-bit ALU control `ealuc` and selects operand B (register or extended immediate).
- Registers the decoded operation into the EX stage through a 2-entry skid buffer with valid/ready handshakes on both sides.
- Flags and counts illegal ALU instructions.

Parameters:
- CNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- clrn  in  1  asynchronous active-low reset
- d_valid  in  1  decode stage holds a valid instruction
- d_ready  out  1  stage can accept (registered)
- d_op  in  6  opcode
- d_funct  in  6  funct field (R-type only)
- d_qa  in  32  register operand A
- d_qb  in  32  register operand B
- d_imm  in  16  immediate field
- d_wn  in  5  destination register number
- flush  in  1  synchronous pipeline flush
- e_ready  in  1  EX stage consumes the head entry this cycle
- e_valid  out  1  head entry valid
- ealuc  out  4  ALU control
- ea  out  32  ALU operand A
- eb  out  32  ALU operand B
- ewn  out  5  destination register
- ewreg  out  1  register write enable
- e_illegal  out  1  head entry is an illegal instruction
- illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions

Interface clock and reset:
- One clock, `clk`.
- Reset `clrn` is asynchronous and active-low.

Behaviour:
- **Reset:** all outputs clear to 0, except `d_ready`, which is 1. Both buffer entries are invalid and the counter is 0.
- **ALU control encoding:** AND=0, OR=1, ADD=2, SUB=6, SLT=7, NOR=12.
- **R-type decode** (`op`=0x00), by `funct`:
  - 0x24 → AND
  - 0x25 → OR
  - 0x20, 0x21 → ADD
  - 0x22, 0x23 → SUB
  - 0x2A → SLT
  - 0x27 → NOR
  - For all of these: `eb`=`d_qb`, `ewreg`=1.
- **I-type decode:**
  - 0x08, 0x09 → ADD, sign-extended immediate
  - 0x0A → SLT, sign-extended immediate
  - 0x0C → AND, zero-extended immediate
  - 0x0D → OR, zero-extended immediate
  - For all of these: `eb`=extended immediate, `ewreg`=1.
- **Any other op/funct:** `ealuc`=0, `ewreg`=0, `e_illegal`=1, `eb`=`d_qb`.
- **Handshakes:**
  - Input transfer occurs when `d_valid & d_ready`.
  - Output transfer occurs when `e_valid & e_ready`.
  - Output fields hold stable while `e_valid=1` and `e_ready=0`.
- **Buffer states:**
  - EMPTY: no entry valid.
  - ONE: head valid, skid empty.
  - FULL: head and skid valid.
- **State transitions:**
  - EMPTY + input → ONE.
  - ONE + input, no output → FULL.
  - ONE + output, no input → EMPTY.
  - ONE + input + output → ONE; the new entry goes to head.
  - FULL + output → ONE; skid moves to head. No input is possible in FULL.
- **`d_ready`:** registered; equals 1 in EMPTY/ONE and 0 in FULL.
- **Latency:** an instruction accepted in cycle N appears at the `e_*` outputs in cycle N+1 when the buffer is EMPTY, or when it is ONE with an output transfer that cycle.
- **Ordering:** strict FIFO; no entry is ever dropped or duplicated.
- **Flush:**
  - Takes priority over all transfers.
  - Next cycle: EMPTY, `e_valid`=0, `d_ready`=1.
  - An input offered in the flush cycle is discarded and not counted.
- **`illegal_cnt`:**
  - Increments on an input transfer of an illegal instruction.
  - Saturates at all-ones.
  - Unaffected by flush; cleared only by reset.
- **Reset mid-operation:** immediate clear of all state, regardless of the clock.

Decomposition:
- Package `alu_defs`:
  - ALUC_AND/OR/ADD/SUB/SLT/NOR constants.
  - OP_RTYPE/ADDI/ADDIU/SLTI/ANDI/ORI constants.
  - FN_* funct constants.
  - Decoded-entry struct {aluc, a, b, wn, wreg, illegal}.
- Sub-module `alu_dec`: purely combinational op/funct/imm → entry decode.
- The top level holds the skid buffer and the counter.

Test Plan:
- **Reset, then decode:** reset, then `op`=0, `funct`=0x22, qa=10, qb=3, `e_ready`=1 → next cycle `e_valid`=1, `ealuc`=6, `ea`=10, `eb`=3, `ewreg`=1.
- **Immediate extension:** ADDI imm=0xFFFF → `eb`=0xFFFFFFFF, `ealuc`=2. ORI imm=0x8000 → `eb`=0x00008000, `ealuc`=1.
- **Backpressure:** `e_ready`=0, three back-to-back valid inputs → two accepted; `d_ready`=0 from the cycle after the second accept. Raise `e_ready` → outputs emerge in order 1, 2, 3 with no loss.
- **Illegal instruction:** `op`=0x23 → `e_illegal`=1, `ewreg`=0, `illegal_cnt`=1. Force the counter to all-ones, feed another illegal → it stays all-ones.
- **Flush while FULL:** flush with a simultaneous `d_valid` → next cycle `e_valid`=0, `d_ready`=1, counter unchanged.
- **Async reset mid-stream:** assert `clrn`=0 between clock edges → `e_valid`=0 immediately and `d_ready`=1.
